uart_rx_loader: RTL
===================

Name: uart_rx_loader

Overview:
- Sequences the byte stream from uart_rx (rx_ready/rx_data/rx_eop) into LC-3 memory write transactions.
- A packet is a big-endian 16-bit origin word followed by big-endian 16-bit data words. Words are written to origin, origin+1, and so on.
- Holds the CPU (cpu_hold) while a load is in progress and reports done/error to the top level.

Parameters:
- MAX_WORDS, 65535: maximum data words per packet. One more word causes an error.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- load_en  in  1  loader armed; bytes are ignored in IDLE when low
- err_clr  in  1  single-cycle pulse; clears error and returns to IDLE
- rx_ready  in  1  byte strobe from uart_rx, one cycle
- rx_data  in  8  received byte, valid with rx_ready
- rx_eop  in  1  end-of-packet strobe from uart_rx, one cycle
- mem_addr  out  16  write address
- mem_wdata  out  16  write data
- mem_wr_valid  out  1  write request
- mem_wr_ready  in  1  memory accepts when valid&&ready
- cpu_hold  out  1  high while state is not IDLE
- start_pc  out  16  origin of last successful load
- word_count  out  16  data words committed in current/last load
- load_done  out  1  one-cycle pulse on successful completion
- load_error  out  1  sticky error flag
- err_code  out  2  01 truncated/odd, 10 overflow, 11 range; 00 none

Behaviour:
- Reset: all outputs 0, state IDLE, pending register empty.
- Reset asserted mid-load: mem_wr_valid drops immediately; the transaction is abandoned.
- States: IDLE, ORIG_LO, DATA_HI, DATA_LO, DRAIN, ERROR.
- IDLE:
  - rx_ready && load_en: latch hi byte, go to ORIG_LO.
  - rx_eop is ignored.
- ORIG_LO:
  - rx_ready: origin={hi,byte}; next_addr=origin; word_count=0; go to DATA_HI.
  - rx_eop: ERROR, code 01.
- DATA_HI:
  - rx_ready: latch hi, go to DATA_LO.
  - rx_eop: go to DRAIN.
- DATA_LO:
  - rx_ready: word complete, then commit (see below).
  - rx_eop: ERROR, code 01 (odd byte count).
- Commit:
  - If the pending write is still valid: ERROR, code 10.
  - Else if word_count==MAX_WORDS, or next_addr wrapped past 16'hFFFF on an earlier word: ERROR, code 11.
  - Else: mem_addr=next_addr, mem_wdata=word, mem_wr_valid=1 on the next cycle; next_addr+1 (16-bit wrap sets an internal wrapped flag); word_count+1; go to DATA_HI.
- Write handshake:
  - mem_wr_valid, mem_addr and mem_wdata are held stable until the cycle mem_wr_ready=1; valid clears on the following edge.
  - Valid never drops without acceptance, including in ERROR: an in-flight write still completes.
- DRAIN:
  - Wait until mem_wr_valid==0.
  - Then pulse load_done for 1 cycle, set start_pc=origin, go to IDLE.
  - Empty packet (origin only): done, word_count=0.
- ERROR:
  - load_error=1, cpu_hold=1; bytes and eop are ignored.
  - err_clr (after any in-flight write drains): clear load_error/err_code, go to IDLE.
  - err_clr with the write not yet drained is held off until drained.
- Simultaneous rx_ready and rx_eop: the byte is processed first, then eop is evaluated against the resulting state in the same cycle.
- load_en deasserted mid-load: no effect; only IDLE checks it.
- Latency: byte rx_ready of low byte to mem_wr_valid = 1 cycle.

Optional Feature:
- Macro UART_LOADER_CKSUM_EN.
- When defined:
  - The final word of the packet is a checksum. The 16-bit sum of origin, all data words and the checksum must be 0.
  - Each completed word is held in a one-word holding register. It is committed only when the next word completes, so the checksum word is never written.
  - At eop in DATA_HI, the running sum is checked:
    - nonzero sum: ERROR, code 01;
    - packet with no checksum word: ERROR, code 01;
    - zero sum: DRAIN.
  - word_count excludes the checksum.
- When undefined: no holding register and no sum logic; every data word is committed as described above.

Test Plan:
- Bytes 30 00 12 34 AB CD, then eop, ready tied 1 -> writes (3000,1234),(3001,ABCD); load_done pulse; start_pc=3000; word_count=2; cpu_hold low after.
- Bytes 30 00 12, then eop -> load_error=1, err_code=01, no write; err_clr -> IDLE, cpu_hold=0.
- Bytes 30 00 11 11 22 22 with mem_wr_ready=0 -> second word gives err_code=10; first write stays valid until ready rises, then ERROR persists.
- Origin FF FF, data 00 01 00 02 -> write (FFFF,0001), then err_code=11; MAX_WORDS=1 with 2 words -> err_code=11.
- rst_n pulled low while mem_wr_valid=1 -> valid and all outputs 0 immediately; new packet 40 00 00 07, then eop -> write (4000,0007), done.
- CKSUM_EN: 30 00 00 05 CF FB, then eop -> write (3000,0005) only, done, word_count=1; last byte changed to FC -> err_code=01, no done.

Source files
------------

// File: rtl/uart_rx_loader.sv
// Purpose: turns the uart_rx byte stream (origin word + data words, big-endian) into LC-3 memory writes.
// Latency: mem_wr_valid rises 1 cycle after the rx_ready of a word's low byte.
// Backpressure: one write is outstanding; a word completing while it is still unaccepted is an overflow error.
// Optional: UART_LOADER_CKSUM_EN treats the last word as a zero-sum checksum and never writes it.
module uart_rx_loader #(
    parameter int unsigned MAX_WORDS = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_en,
    input  logic        err_clr,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_eop,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_wr_valid,
    input  logic        mem_wr_ready,
    output logic        cpu_hold,
    output logic [15:0] start_pc,
    output logic [15:0] word_count,
    output logic        load_done,
    output logic        load_error,
    output logic [1:0]  err_code
);

    localparam logic [15:0] MAX_W = 16'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE, S_ORIG_LO, S_DATA_HI, S_DATA_LO, S_DRAIN, S_ERROR
    } state_t;

    state_t      state, state_n;
    logic [7:0]  hi_byte, hi_n;
    logic [15:0] origin, origin_n;
    logic [15:0] next_addr, next_addr_n;
    logic        wrapped, wrapped_n;
    logic [15:0] count_n, addr_n, wdata_n, start_pc_n;
    logic        vld_n, done_n, err_n, clr_pend, clr_pend_n;
    logic [1:0]  code_n;
    logic [15:0] word, cm_word;
    logic        cm_go;
`ifdef UART_LOADER_CKSUM_EN
    logic [15:0] sum, sum_n, hold_word, hold_word_n;
    logic        hold_vld, hold_vld_n;
`endif

    assign cpu_hold = (state != S_IDLE);
    assign word     = {hi_byte, rx_data};

    // Next state and datapath: byte first, then eop against the post-byte state.
    always_comb begin
        state_n     = state;
        hi_n        = hi_byte;
        origin_n    = origin;
        next_addr_n = next_addr;
        wrapped_n   = wrapped;
        count_n     = word_count;
        addr_n      = mem_addr;
        wdata_n     = mem_wdata;
        vld_n       = mem_wr_valid && !mem_wr_ready;
        start_pc_n  = start_pc;
        done_n      = 1'b0;
        err_n       = load_error;
        code_n      = err_code;
        clr_pend_n  = clr_pend;
        cm_go       = 1'b0;
        cm_word     = word;
`ifdef UART_LOADER_CKSUM_EN
        sum_n       = sum;
        hold_word_n = hold_word;
        hold_vld_n  = hold_vld;
`endif
        if (rx_ready) begin
            case (state)
                S_IDLE: begin
                    if (load_en) begin
                        hi_n    = rx_data;
                        state_n = S_ORIG_LO;
                    end
                end
                S_ORIG_LO: begin
                    origin_n    = word;
                    next_addr_n = word;
                    wrapped_n   = 1'b0;
                    count_n     = 16'd0;
                    state_n     = S_DATA_HI;
`ifdef UART_LOADER_CKSUM_EN
                    sum_n       = word;
                    hold_vld_n  = 1'b0;
`endif
                end
                S_DATA_HI: begin
                    hi_n    = rx_data;
                    state_n = S_DATA_LO;
                end
                S_DATA_LO: begin
                    state_n = S_DATA_HI;
`ifdef UART_LOADER_CKSUM_EN
                    // The previous word is only known not to be the checksum now.
                    sum_n       = sum + word;
                    hold_word_n = word;
                    hold_vld_n  = 1'b1;
                    cm_go       = hold_vld;
                    cm_word     = hold_word;
`else
                    cm_go       = 1'b1;
`endif
                end
                default: ;
            endcase
        end

        if (cm_go) begin
            if (mem_wr_valid && !mem_wr_ready) begin
                state_n = S_ERROR;
                err_n   = 1'b1;
                code_n  = 2'b10;
            end else if (word_count == MAX_W || wrapped) begin
                state_n = S_ERROR;
                err_n   = 1'b1;
                code_n  = 2'b11;
            end else begin
                addr_n      = next_addr;
                wdata_n     = cm_word;
                vld_n       = 1'b1;
                next_addr_n = next_addr + 16'd1;
                if (next_addr == 16'hFFFF) wrapped_n = 1'b1;
                count_n     = word_count + 16'd1;
            end
        end

        if (rx_eop) begin
            case (state_n)
                S_ORIG_LO, S_DATA_LO: begin
                    state_n = S_ERROR;
                    err_n   = 1'b1;
                    code_n  = 2'b01;
                end
                S_DATA_HI: begin
`ifdef UART_LOADER_CKSUM_EN
                    if (!hold_vld_n || sum_n != 16'd0) begin
                        state_n = S_ERROR;
                        err_n   = 1'b1;
                        code_n  = 2'b01;
                    end else begin
                        state_n = S_DRAIN;
                    end
`else
                    state_n = S_DRAIN;
`endif
                end
                default: ;
            endcase
        end

        case (state)
            S_DRAIN: begin
                if (!mem_wr_valid) begin
                    done_n     = 1'b1;
                    start_pc_n = origin;
                    state_n    = S_IDLE;
                end
            end
            S_ERROR: begin
                // A clear seen while a write is still in flight is remembered until it drains.
                if (err_clr || clr_pend) begin
                    if (!mem_wr_valid) begin
                        err_n      = 1'b0;
                        code_n     = 2'b00;
                        clr_pend_n = 1'b0;
                        state_n    = S_IDLE;
                    end else begin
                        clr_pend_n = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_byte      <= 8'd0;
            origin       <= 16'd0;
            next_addr    <= 16'd0;
            wrapped      <= 1'b0;
            word_count   <= 16'd0;
            mem_addr     <= 16'd0;
            mem_wdata    <= 16'd0;
            mem_wr_valid <= 1'b0;
            start_pc     <= 16'd0;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            err_code     <= 2'b00;
            clr_pend     <= 1'b0;
`ifdef UART_LOADER_CKSUM_EN
            sum          <= 16'd0;
            hold_word    <= 16'd0;
            hold_vld     <= 1'b0;
`endif
        end else begin
            hi_byte      <= hi_n;
            origin       <= origin_n;
            next_addr    <= next_addr_n;
            wrapped      <= wrapped_n;
            word_count   <= count_n;
            mem_addr     <= addr_n;
            mem_wdata    <= wdata_n;
            mem_wr_valid <= vld_n;
            start_pc     <= start_pc_n;
            load_done    <= done_n;
            load_error   <= err_n;
            err_code     <= code_n;
            clr_pend     <= clr_pend_n;
`ifdef UART_LOADER_CKSUM_EN
            sum          <= sum_n;
            hold_word    <= hold_word_n;
            hold_vld     <= hold_vld_n;
`endif
        end
    end

endmodule
